reg_port_arbiter: RTL
=====================

REG_PORT_ARBITER -- requirements
Module: reg_port_arbiter

Interface
REQ-001 SHALL have parameter UUID, default 0, instance identifier with no functional effect.
REQ-002 SHALL have parameter NAME, default "", instance label with no functional effect.
REQ-003 SHALL have parameter BIT_WIDTH, default 8, data width of the shared register.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  input  4  per-requester request; held until accepted.
REQ-007 SHALL have port req_write  input  4  per-requester op: 1 = write, 0 = read.
REQ-008 SHALL have port req_data  input  4*BIT_WIDTH  write data; requester i at [i*BIT_WIDTH +: BIT_WIDTH].
REQ-009 SHALL have port req_ready  output  4  one-hot acceptance; a request is accepted when valid and ready are both high.
REQ-010 SHALL have port rsp_valid  output  4  one-hot, one-cycle read-response strobe.
REQ-011 SHALL have port rsp_data  output  BIT_WIDTH  read data; qualified by rsp_valid.
REQ-012 SHALL have port reg_save  output  1  save strobe to the shared register.
REQ-013 SHALL have port reg_load  output  1  load strobe to the shared register.
REQ-014 SHALL have port reg_in  output  BIT_WIDTH  write data to the shared register.
REQ-015 SHALL have port reg_out  input  BIT_WIDTH  output value of the shared register.
REQ-016 SHALL have port reg_rst  output  1  active-high reset to the shared register.
REQ-017 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, WR and RD.
REQ-019 In IDLE with any req_valid high, SHALL grant exactly one requester, combinationally, via req_ready.
REQ-020 Arbitration SHALL be round-robin: the first valid requester at or after rr_ptr (index ascending, wrapping 3->0) wins.
REQ-021 On acceptance of requester g, SHALL latch g, req_write[g] and the req_data slice of g, and set rr_ptr to (g+1) mod 4.
REQ-022 On acceptance, next state SHALL be WR if req_write[g] = 1, else RD.
REQ-023 In IDLE with no req_valid high, SHALL stay in IDLE with req_ready = 0.
REQ-024 WR SHALL last exactly one cycle with reg_save = 1 and reg_in = the latched data, then return to IDLE.
REQ-025 RD SHALL last exactly one cycle with reg_load = 1.
REQ-026 At the edge ending RD, SHALL register rsp_data <= reg_out and set rsp_valid[g] = 1, then return to IDLE.
REQ-027 rsp_valid SHALL be high for exactly one cycle, coinciding with the next IDLE cycle.
REQ-028 rsp_data SHALL hold its value until the next read completes.
REQ-029 In WR and RD, req_ready SHALL be 0 and req_valid/req_write/req_data SHALL be ignored.
REQ-030 A read response and a new grant MAY occur in the same IDLE cycle.
REQ-031 Throughput SHALL be one accepted request per 2 cycles.
REQ-032 Request-to-register latency SHALL be 1 cycle; read-to-response latency SHALL be 2 cycles from acceptance.
REQ-033 reg_save, reg_load and reg_in SHALL be 0 outside WR and RD respectively.
REQ-034 reg_in SHALL also be 0 outside WR.
REQ-035 reg_rst SHALL equal the inverse of rst (combinational).
REQ-036 A requester dropping req_valid before acceptance SHALL cause no side effect.
REQ-037 Fairness: a continuously valid requester SHALL be granted within 4 consecutive grants.

Reset
REQ-038 When rst = 0 at a posedge, SHALL set state = IDLE, rr_ptr = 0, rsp_valid = 0 and rsp_data = 0.
REQ-039 While rst = 0, SHALL hold req_ready = 0, reg_save = 0, reg_load = 0, busy = 0 and reg_rst = 1.
REQ-040 Reset asserted during WR or RD SHALL abort the operation and produce no rsp_valid.

Verification
REQ-041 Reset held 2 cycles with all inputs X-free random -> all outputs 0, reg_rst = 1; after release, busy = 0.
REQ-042 Requester 1 writes 0xA5, then requester 2 reads.
  - Write: req_ready = 4'b0010, then reg_save = 1 with reg_in = 0xA5 for one cycle.
  - Read: reg_load = 1, then rsp_valid = 4'b0100 with rsp_data = 0xA5.
REQ-043 All four requesters hold writes (data 0x10..0x13) -> grant order 0,1,2,3,0; reg_in sequence 0x10, 0x11, 0x12, 0x13; rr_ptr wraps.
REQ-044 With rr_ptr = 2, requesters 0 and 3 valid -> 3 granted first, then 0.
REQ-045 rst driven low in the WR cycle of a 0x3C write -> next cycle reg_save = 0, state IDLE, reg_rst = 1, no rsp_valid.
REQ-046 A read with no prior write after reset -> rsp_data = 0x00 two cycles after acceptance.

Source files
------------

// File: rtl/reg_port_arbiter.sv
// Four-port round-robin arbiter fronting a single shared register.
// Each accepted request takes one WR or RD cycle; read data returns one cycle later.
module reg_port_arbiter #(
   parameter int UUID      = 0,
   parameter     NAME      = "",
   parameter int BIT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [3:0]             req_valid,
   input  logic [3:0]             req_write,
   input  logic [4*BIT_WIDTH-1:0] req_data,
   output logic [3:0]             req_ready,
   output logic [3:0]             rsp_valid,
   output logic [BIT_WIDTH-1:0]   rsp_data,
   output logic                   reg_save,
   output logic                   reg_load,
   output logic [BIT_WIDTH-1:0]   reg_in,
   input  logic [BIT_WIDTH-1:0]   reg_out,
   output logic                   reg_rst,
   output logic                   busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WR   = 2'd1;
   localparam logic [1:0] S_RD   = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [1:0]           rr_ptr_q, rr_ptr_d;
   logic [1:0]           gnt_q, gnt_d;
   logic [BIT_WIDTH-1:0] data_q, data_d;
   logic [3:0]           rsp_valid_q, rsp_valid_d;
   logic [BIT_WIDTH-1:0] rsp_data_q, rsp_data_d;

   logic                 gnt_any;
   logic [1:0]           gnt_idx;
   logic [1:0]           idx;
   logic [BIT_WIDTH-1:0] gnt_data;
   logic                 accept;

   // First valid requester scanning upward from rr_ptr, wrapping 3->0.
   always_comb begin
      gnt_any  = 1'b0;
      gnt_idx  = 2'd0;
      idx      = 2'd0;
      gnt_data = '0;
      for (int k = 0; k < 4; k++) begin
         idx = rr_ptr_q + 2'(k);
         if (!gnt_any && req_valid[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = idx;
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (gnt_idx == 2'(i)) gnt_data = req_data[i*BIT_WIDTH +: BIT_WIDTH];
      end
   end

   assign accept = rst && (state_q == S_IDLE) && gnt_any;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      gnt_d       = gnt_q;
      data_d      = data_q;
      rsp_valid_d = 4'b0000;
      rsp_data_d  = rsp_data_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               gnt_d    = gnt_idx;
               data_d   = gnt_data;
               rr_ptr_d = gnt_idx + 2'd1;
               state_d  = req_write[gnt_idx] ? S_WR : S_RD;
            end
         end
         S_WR: state_d = S_IDLE;
         S_RD: begin
            rsp_data_d  = reg_out;
            rsp_valid_d = 4'b0001 << gnt_q;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= 2'd0;
         gnt_q       <= 2'd0;
         data_q      <= '0;
         rsp_valid_q <= 4'b0000;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         gnt_q       <= gnt_d;
         data_q      <= data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   // Strobes are gated by rst so an in-flight op is cut off the moment reset asserts.
   assign req_ready = accept ? (4'b0001 << gnt_idx) : 4'b0000;
   assign reg_save  = rst && (state_q == S_WR);
   assign reg_load  = rst && (state_q == S_RD);
   assign reg_in    = reg_save ? data_q : '0;
   assign reg_rst   = ~rst;
   assign busy      = rst && (state_q != S_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

endmodule
